// File: rtl/vc_arb_crossbar_if.sv
// Handshake bundle for vc_arb_crossbar: N input val/rdy lanes and N output val/rdy lanes.
// Latency: none; wires only.
// Backpressure: carries in_rdy (crossbar -> sender) and out_rdy (sink -> crossbar).
//
// Signals:
//   in_msg/in_dest/in_val -> crossbar, in_rdy <- crossbar   (one lane per input)
//   out_msg/out_val <- crossbar, out_rdy -> crossbar        (one lane per output)
//   bad_dest <- crossbar                                     (dropped-message pulse)
//   cur_sd/in_sd -> crossbar, only when VC_XBAR_SD_ISOLATE_EN is defined
// Modports: master = sender/sink side, slave = crossbar side.
interface vc_arb_crossbar_if #(
    parameter int P_NBITS  = 32,
    parameter int P_NPORTS = 4
);
    localparam int P_DESTW = $clog2(P_NPORTS);

    logic [P_NPORTS*P_NBITS-1:0] in_msg;
    logic [P_NPORTS*P_DESTW-1:0] in_dest;
    logic [P_NPORTS-1:0]         in_val;
    logic [P_NPORTS-1:0]         in_rdy;
    logic [P_NPORTS*P_NBITS-1:0] out_msg;
    logic [P_NPORTS-1:0]         out_val;
    logic [P_NPORTS-1:0]         out_rdy;
    logic                        bad_dest;

`ifdef VC_XBAR_SD_ISOLATE_EN
    logic                        cur_sd;
    logic [P_NPORTS-1:0]         in_sd;

    modport master (
        output in_msg, in_dest, in_val, out_rdy, cur_sd, in_sd,
        input  in_rdy, out_msg, out_val, bad_dest
    );
    modport slave (
        input  in_msg, in_dest, in_val, out_rdy, cur_sd, in_sd,
        output in_rdy, out_msg, out_val, bad_dest
    );
`else
    modport master (
        output in_msg, in_dest, in_val, out_rdy,
        input  in_rdy, out_msg, out_val, bad_dest
    );
    modport slave (
        input  in_msg, in_dest, in_val, out_rdy,
        output in_rdy, out_msg, out_val, bad_dest
    );
`endif
endinterface

// File: rtl/vc_arb_crossbar.sv
// N x N message crossbar, round-robin arbiter and one-entry register per output.
// Latency: 1 cycle from input fire to out_val.
// Backpressure: an output accepts only when its register is empty or draining this cycle.
//
// Ports:
//   clk      - clock, all state on posedge
//   reset_n  - asynchronous active-low reset; in_rdy forced low while asserted
//   xb       - vc_arb_crossbar_if.slave (message lanes, handshakes, bad_dest)
// Optional: VC_XBAR_SD_ISOLATE_EN adds per-input security-domain gating (xb.cur_sd, xb.in_sd).
module vc_arb_crossbar #(
    parameter int P_NBITS  = 32,
    parameter int P_NPORTS = 4
) (
    input logic            clk,
    input logic            reset_n,
    vc_arb_crossbar_if.slave xb
);
    localparam int P_DESTW = $clog2(P_NPORTS);
    // One extra bit so dest >= P_NPORTS and ptr+offset never overflow.
    localparam logic [P_DESTW:0] LP_NPORTS = (P_DESTW+1)'(P_NPORTS);

    logic [P_NPORTS*P_NBITS-1:0] out_msg_q;
    logic [P_NPORTS-1:0]         out_val_q;
    logic                        bad_q;
    logic [P_DESTW-1:0]          ptr [P_NPORTS];

    logic [P_NPORTS-1:0]         elig;
    logic [P_NPORTS-1:0]         bad_hit;
    logic [P_NPORTS-1:0]         space;
    logic [P_NPORTS-1:0]         grant_vld;
    logic [P_DESTW-1:0]          grant_idx [P_NPORTS];
    logic [P_NPORTS-1:0]         in_rdy_c;

`ifdef VC_XBAR_SD_ISOLATE_EN
    // Inputs from another domain are invisible: no request, no drop, no pointer move.
    assign elig = xb.in_val & ~(xb.in_sd ^ {P_NPORTS{xb.cur_sd}});
`else
    assign elig = xb.in_val;
`endif

    always_comb begin
        for (int i = 0; i < P_NPORTS; i++) begin
            bad_hit[i] = elig[i] && ({1'b0, xb.in_dest[i*P_DESTW +: P_DESTW]} >= LP_NPORTS);
        end
    end

    // Per output: scan requesters starting at ptr, wrapping, and take the first one.
    always_comb begin : p_arb
        logic [P_DESTW:0]   cand;
        logic [P_DESTW-1:0] cidx;
        cand      = '0;
        cidx      = '0;
        space     = ~out_val_q | xb.out_rdy;
        grant_vld = '0;
        for (int o = 0; o < P_NPORTS; o++) begin
            grant_idx[o] = '0;
            for (int k = 0; k < P_NPORTS; k++) begin
                cand = {1'b0, ptr[o]} + (P_DESTW+1)'(k);
                if (cand >= LP_NPORTS) begin
                    cand = cand - LP_NPORTS;
                end
                cidx = cand[P_DESTW-1:0];
                if (space[o] && !grant_vld[o] && elig[cidx] &&
                    (xb.in_dest[cidx*P_DESTW +: P_DESTW] == P_DESTW'(o))) begin
                    grant_vld[o] = 1'b1;
                    grant_idx[o] = cidx;
                end
            end
        end
    end

    // Each input names one destination, so it can be granted by at most one output.
    always_comb begin
        in_rdy_c = bad_hit;
        for (int o = 0; o < P_NPORTS; o++) begin
            if (grant_vld[o]) begin
                in_rdy_c[grant_idx[o]] = 1'b1;
            end
        end
    end

    assign xb.in_rdy   = in_rdy_c & {P_NPORTS{reset_n}};
    assign xb.out_msg  = out_msg_q;
    assign xb.out_val  = out_val_q;
    assign xb.bad_dest = bad_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_msg_q <= '0;
            out_val_q <= '0;
            bad_q     <= 1'b0;
            for (int o = 0; o < P_NPORTS; o++) begin
                ptr[o] <= '0;
            end
        end else begin
            bad_q <= |bad_hit;
            for (int o = 0; o < P_NPORTS; o++) begin
                if (grant_vld[o]) begin
                    // Load also covers the replace-while-draining case.
                    out_msg_q[o*P_NBITS +: P_NBITS] <= xb.in_msg[grant_idx[o]*P_NBITS +: P_NBITS];
                    out_val_q[o] <= 1'b1;
                    ptr[o]       <= (grant_idx[o] == P_DESTW'(P_NPORTS-1)) ? '0 : grant_idx[o] + 1'b1;
                end else if (xb.out_rdy[o]) begin
                    out_val_q[o] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_vc_arb_crossbar.sv
// Directed bench for vc_arb_crossbar: a 4-port and a 3-port instance, checked every cycle
// against a queue/array model of the arbitration rules, plus hand-computed literal checks.
// Build with +define+VC_XBAR_SD_ISOLATE_EN to also exercise security-domain gating.
module tb_vc_arb_crossbar;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vc_arb_crossbar_if #(.P_NBITS(32), .P_NPORTS(4)) if0 ();
    vc_arb_crossbar_if #(.P_NBITS(32), .P_NPORTS(3)) if1 ();

    vc_arb_crossbar #(.P_NBITS(32), .P_NPORTS(4)) u_x4 (.clk(clk), .reset_n(rst_n), .xb(if0.slave));
    vc_arb_crossbar #(.P_NBITS(32), .P_NPORTS(3)) u_x3 (.clk(clk), .reset_n(rst_n), .xb(if1.slave));

    int n_vec  = 0;
    int n_miss = 0;

    // Model state: [instance][output]
    logic        m_val [2][4];
    logic [31:0] m_msg [2][4];
    int          m_ptr [2][4];
    logic        m_bad [2];
    int          grant_log[$];   // winners of output 1 on the 4-port instance

    logic [3:0] cont_exp [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    int         cont_ord [6] = '{0, 1, 3, 0, 1, 3};

    logic       sd0_cur, sd1_cur;
    logic [3:0] sd0_in;
    logic [2:0] sd1_in;
`ifdef VC_XBAR_SD_ISOLATE_EN
    assign sd0_cur = if0.cur_sd;
    assign sd0_in  = if0.in_sd;
    assign sd1_cur = if1.cur_sd;
    assign sd1_in  = if1.in_sd;
`else
    assign sd0_cur = 1'b0;
    assign sd0_in  = 4'b0;
    assign sd1_cur = 1'b0;
    assign sd1_in  = 3'b0;
`endif

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Compare one instance against the model, then advance the model by one clock.
    task automatic model_cycle(input int d, input int n, input logic rst,
                               input logic [127:0] imsg, input logic [7:0] idest,
                               input logic [3:0] ival, input logic [3:0] irdy,
                               input logic [3:0] ordy, input logic [127:0] omsg,
                               input logic [3:0] oval, input logic obad,
                               input logic csd, input logic [3:0] isd);
        logic [3:0]   e_rdy;
        logic [3:0]   e_val;
        logic [127:0] e_msg;
        logic         any_bad;
        int           win [4];
        int           dst;
        int           i;
        string        tag;
        tag = (d == 0) ? "x4" : "x3";
        if (!rst) begin
            for (int o = 0; o < 4; o++) begin
                m_val[d][o] = 1'b0;
                m_msg[d][o] = 32'h0;
                m_ptr[d][o] = 0;
            end
            m_bad[d] = 1'b0;
        end
        e_rdy   = '0;
        e_val   = '0;
        e_msg   = '0;
        any_bad = 1'b0;
        for (int o = 0; o < 4; o++) win[o] = -1;
        for (int o = 0; o < n; o++) begin
            e_val[o]          = m_val[d][o];
            e_msg[32*o +: 32] = m_msg[d][o];
        end
        if (rst) begin
            for (int j = 0; j < n; j++) begin
                dst = int'(idest[2*j +: 2]);
                if (ival[j] && isd[j] == csd && dst >= n) begin
                    e_rdy[j] = 1'b1;
                    any_bad  = 1'b1;
                end
            end
            for (int o = 0; o < n; o++) begin
                if (!m_val[d][o] || ordy[o]) begin
                    for (int k = 0; k < n; k++) begin
                        i   = (m_ptr[d][o] + k) % n;
                        dst = int'(idest[2*i +: 2]);
                        if (win[o] < 0 && ival[i] && isd[i] == csd && dst == o) win[o] = i;
                    end
                end
                if (win[o] >= 0) e_rdy[win[o]] = 1'b1;
            end
        end
        chk({tag, "_in_rdy"},   128'(irdy), 128'(e_rdy));
        chk({tag, "_out_val"},  128'(oval), 128'(e_val));
        chk({tag, "_out_msg"},  omsg, e_msg);
        chk({tag, "_bad_dest"}, 128'(obad), 128'(m_bad[d]));
        if (rst) begin
            for (int o = 0; o < n; o++) begin
                if (win[o] >= 0) begin
                    m_msg[d][o] = imsg[32*win[o] +: 32];
                    m_val[d][o] = 1'b1;
                    m_ptr[d][o] = (win[o] + 1) % n;
                    if (d == 0 && o == 1) grant_log.push_back(win[o]);
                end else if (m_val[d][o] && ordy[o]) begin
                    m_val[d][o] = 1'b0;
                end
            end
            m_bad[d] = any_bad;
        end
    endtask

    always @(negedge clk) begin
        model_cycle(0, 4, rst_n, if0.in_msg, if0.in_dest, if0.in_val, if0.in_rdy,
                    if0.out_rdy, if0.out_msg, if0.out_val, if0.bad_dest, sd0_cur, sd0_in);
        model_cycle(1, 3, rst_n, {32'b0, if1.in_msg}, {2'b0, if1.in_dest}, {1'b0, if1.in_val},
                    {1'b0, if1.in_rdy}, {1'b0, if1.out_rdy}, {32'b0, if1.out_msg},
                    {1'b0, if1.out_val}, if1.bad_dest, sd1_cur, {1'b0, sd1_in});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    localparam logic [127:0] PERM_MSG  = {32'h0000_00D3, 32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
    localparam logic [7:0]   PERM_DEST = {2'd1, 2'd0, 2'd3, 2'd2};

    initial begin
        if0.in_msg  = PERM_MSG;
        if0.in_dest = PERM_DEST;
        if0.in_val  = 4'hF;
        if0.out_rdy = 4'hF;
        if1.in_msg  = '0;
        if1.in_dest = {2'd3, 2'd3, 2'd3};
        if1.in_val  = 3'b111;
        if1.out_rdy = 3'b111;
`ifdef VC_XBAR_SD_ISOLATE_EN
        if0.cur_sd = 1'b0;
        if0.in_sd  = '0;
        if1.cur_sd = 1'b0;
        if1.in_sd  = '0;
`endif
        // Reset state, with valid traffic presented during reset.
        mid();
        chk("rst_in_rdy4", 128'(if0.in_rdy), 128'h0);
        chk("rst_in_rdy3", 128'(if1.in_rdy), 128'h0);
        chk("rst_out_val", 128'(if0.out_val), 128'h0);
        step();
        if0.in_val = '0;
        if1.in_val = '0;
        rst_n      = 1'b1;
        mid();
        chk("rst_bad3", 128'(if1.bad_dest), 128'h0);

        // Permutation: every output loads in the same cycle.
        step();
        if0.in_val = 4'hF;
        mid();
        chk("perm_in_rdy", 128'(if0.in_rdy), 128'hF);
        step();
        if0.in_val = '0;
        mid();
        chk("perm_out_val", 128'(if0.out_val), 128'hF);
        chk("perm_msg2", 128'(if0.out_msg[64 +: 32]), 128'hA0);
        chk("perm_msg0", 128'(if0.out_msg[0 +: 32]),  128'hC2);
        chk("perm_msg1", 128'(if0.out_msg[32 +: 32]), 128'hD3);

        // Contention: inputs 0,1,3 all target output 1.
        step();
        grant_log.delete();
        if0.in_msg  = {32'h33, 32'h0, 32'h31, 32'h30};
        if0.in_dest = {2'd1, 2'd0, 2'd1, 2'd1};
        if0.in_val  = 4'b1011;
        for (int c = 0; c < 6; c++) begin
            mid();
            chk($sformatf("cont_rdy%0d", c), 128'(if0.in_rdy), 128'(cont_exp[c]));
            step();
        end
        if0.in_val = '0;
        chk("cont_log_n", 128'(grant_log.size()), 128'd6);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("cont_ord%0d", j), 128'(grant_log[j]), 128'(cont_ord[j]));
        end

        // Backpressure on output 0, then replace-while-draining.
        if0.in_msg[64 +: 32] = 32'h1111_0001;
        if0.in_dest = 8'h00;
        if0.in_val  = 4'b0100;
        if0.out_rdy = 4'b1110;
        mid();
        chk("bp_load_rdy", 128'(if0.in_rdy), 128'h4);
        step();
        if0.in_msg[64 +: 32] = 32'h2222_0002;
        for (int c = 0; c < 2; c++) begin
            mid();
            chk($sformatf("bp_stall_rdy%0d", c), 128'(if0.in_rdy), 128'h0);
            chk($sformatf("bp_stall_msg%0d", c), 128'(if0.out_msg[0 +: 32]), 128'h1111_0001);
            step();
        end
        if0.out_rdy = 4'hF;
        mid();
        chk("bp_release_rdy", 128'(if0.in_rdy), 128'h4);
        step();
        if0.in_val = '0;
        mid();
        chk("bp_next_val", 128'(if0.out_val[0]), 128'h1);
        chk("bp_next_msg", 128'(if0.out_msg[0 +: 32]), 128'h2222_0002);

        // Mid-traffic reset with all outputs full.
        step();
        if0.in_msg  = PERM_MSG;
        if0.in_dest = PERM_DEST;
        if0.in_val  = 4'hF;
        if0.out_rdy = 4'h0;
        step();
        if0.in_val = '0;
        mid();
        chk("rst2_full", 128'(if0.out_val), 128'hF);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst2_async_val", 128'(if0.out_val), 128'h0);
        chk("rst2_async_msg", if0.out_msg, 128'h0);
        step();
        step();
        rst_n       = 1'b1;
        if0.out_rdy = 4'hF;
        step();
        step();
        mid();
        chk("rst2_no_emit", 128'(if0.out_val), 128'h0);
        // Pointer 0 back at 0: in2 beats in3 (a stale pointer of 3 would pick in3).
        step();
        if0.in_msg  = {32'hF3, 32'hE2, 32'h0, 32'h0};
        if0.in_dest = 8'h00;
        if0.in_val  = 4'b1100;
        mid();
        chk("rst2_ptr0", 128'(if0.in_rdy), 128'h4);
        step();
        if0.in_val = 4'b1000;
        mid();
        chk("rst2_ptr_next", 128'(if0.in_rdy), 128'h8);
        chk("rst2_ptr_msg", 128'(if0.out_msg[0 +: 32]), 128'hE2);
        step();
        if0.in_val = '0;

`ifdef VC_XBAR_SD_ISOLATE_EN
        // Domain gating: in0 is domain 1, in1 is domain 0, both target output 0.
        step();
        if0.in_msg  = {32'h0, 32'h0, 32'h5D01, 32'h5D00};
        if0.in_sd   = 4'b0001;
        if0.cur_sd  = 1'b0;
        if0.in_val  = 4'b0011;
        mid();
        chk("sd_only_in1", 128'(if0.in_rdy), 128'h2);
        step();
        if0.in_val = 4'b0001;
        if0.cur_sd = 1'b1;
        mid();
        chk("sd_in0_now", 128'(if0.in_rdy), 128'h1);
        step();
        if0.in_val = '0;
        if0.in_sd  = '0;
        if0.cur_sd = 1'b0;
        mid();
        chk("sd_in0_msg", 128'(if0.out_msg[0 +: 32]), 128'h5D00);
`endif

        // Out-of-range destination on the 3-port instance.
        step();
        if1.in_msg  = {32'h0, 32'hBAD1, 32'h0};
        if1.in_dest = {2'd0, 2'd3, 2'd0};
        if1.in_val  = 3'b010;
        mid();
        chk("bad_in_rdy", 128'(if1.in_rdy), 128'h2);
        chk("bad_pulse_pre", 128'(if1.bad_dest), 128'h0);
        step();
        if1.in_val = '0;
        mid();
        chk("bad_pulse", 128'(if1.bad_dest), 128'h1);
        chk("bad_no_val", 128'(if1.out_val), 128'h0);
        step();
        mid();
        chk("bad_pulse_end", 128'(if1.bad_dest), 128'h0);
        chk("bad_no_val2", 128'(if1.out_val), 128'h0);

        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
